tft_byte_sender: RTL and testbench

TFT_BYTE_SENDER -- requirements
Module: tft_byte_sender

---
 rtl/tft_pkg.sv | 18 +
 rtl/tft_byte_sender_if.sv | 25 ++
 rtl/tft_byte_sender.sv | 113 +++++++++++
 tb/tb_tft_byte_sender.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tft_pkg.sv
// Shared TFT definitions: sender FSM encoding and default SPI timing constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tft_pkg;

    // Byte sender states, shared with the init/scene producers for debug visibility
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } tft_state_t;

    // SCK half-period in clk cycles (legal 1..255)
    localparam int TFT_CLK_DIV = 2;
    // clk cycles CS stays low after the last SCK falling edge (legal 1..15)
    localparam int TFT_CS_HOLD = 1;

endpackage

// File: rtl/tft_byte_sender_if.sv
// Producer <-> byte sender strobe bus plus the panel-side SPI lines.
// Latency: n/a (wiring only).
// Backpressure: producer must wait for tft_busy=0 and tft_transmit=0 before the next strobe.
interface tft_byte_sender_if;
    logic       tft_transmit;
    logic [7:0] tft_data;
    logic       tft_dc;
    logic       tft_busy;
    logic       tft_sck;
    logic       tft_mosi;
    logic       tft_cs;
    logic       tft_dc_out;

    // producer side: issues strobes, observes busy and the panel lines
    modport master (
        output tft_transmit, tft_data, tft_dc,
        input  tft_busy, tft_sck, tft_mosi, tft_cs, tft_dc_out
    );

    // sender side: accepts strobes, drives busy and the panel lines
    modport slave (
        input  tft_transmit, tft_data, tft_dc,
        output tft_busy, tft_sck, tft_mosi, tft_cs, tft_dc_out
    );
endinterface

// File: rtl/tft_byte_sender.sv
// Serialises one byte per strobe onto a mode-0 SPI link (MSB first) with registered D/C.
// Latency: busy rises the cycle after the strobe; busy lasts 16*CLK_DIV + CS_HOLD cycles.
// Backpressure: strobes while not IDLE are dropped; producer waits for busy=0.
module tft_byte_sender
    import tft_pkg::*;
#(
    parameter int CLK_DIV = TFT_CLK_DIV,
    parameter int CS_HOLD = TFT_CS_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    tft_byte_sender_if.slave bus
);

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [3:0] HOLD_LAST = 4'(CS_HOLD - 1);

    tft_state_t r_state;
    tft_state_t w_state_nxt;

    logic [7:0] r_div;
    logic [2:0] r_bit;
    logic [3:0] r_hold;
    logic [7:0] r_shift;
    logic       r_sck;
    logic       r_dc;

    logic w_accept;
    logic w_div_tc;
    logic w_fall;
    logic w_last_fall;
    logic w_hold_tc;

    // strobe is only honoured in IDLE; anything arriving mid-byte is dropped
    assign w_accept    = (r_state == ST_IDLE) && bus.tft_transmit;
    assign w_div_tc    = (r_div == DIV_LAST);
    // a falling SCK edge happens when the divider expires while SCK is high
    assign w_fall      = (r_state == ST_SHIFT) && w_div_tc && r_sck;
    assign w_last_fall = w_fall && (r_bit == 3'd7);
    assign w_hold_tc   = (r_state == ST_HOLD) && (r_hold == HOLD_LAST);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // next-state: IDLE -> SHIFT on strobe, SHIFT -> HOLD after 8th fall, HOLD -> IDLE after CS_HOLD
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)    w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_last_fall) w_state_nxt = ST_HOLD;
            ST_HOLD:  if (w_hold_tc)   w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    // outputs derive from state and datapath registers only, so reset reaches pins at once
    always_comb begin
        bus.tft_busy   = (r_state != ST_IDLE);
        bus.tft_cs     = (r_state == ST_IDLE);
        bus.tft_sck    = r_sck;
        bus.tft_mosi   = r_shift[7];
        bus.tft_dc_out = r_dc;
    end

    // half-period divider: runs only in SHIFT, restarts on every SCK toggle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     r_div <= 8'd0;
        else if (r_state != ST_SHIFT) r_div <= 8'd0;
        else if (w_div_tc)           r_div <= 8'd0;
        else                         r_div <= r_div + 8'd1;
    end

    // SCK toggles at each divider expiry; the 8th fall leaves it low for HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      r_sck <= 1'b0;
        else if (r_state != ST_SHIFT) r_sck <= 1'b0;
        else if (w_div_tc)            r_sck <= ~r_sck;
    end

    // bit counter counts falling edges 0..7 and is cleared rather than wrapped
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_bit <= 3'd0;
        else if (w_accept)    r_bit <= 3'd0;
        else if (w_last_fall) r_bit <= 3'd0;
        else if (w_fall)      r_bit <= r_bit + 3'd1;
    end

    // shift register: load on strobe, advance on the first 7 falls, clear as HOLD ends so MOSI idles low
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         r_shift <= 8'd0;
        else if (w_accept)               r_shift <= bus.tft_data;
        else if (w_fall && !w_last_fall) r_shift <= {r_shift[6:0], 1'b0};
        else if (w_hold_tc)              r_shift <= 8'd0;
    end

    // CS hold counter, active only in HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     r_hold <= 4'd0;
        else if (r_state != ST_HOLD) r_hold <= 4'd0;
        else if (w_hold_tc)          r_hold <= 4'd0;
        else                         r_hold <= r_hold + 4'd1;
    end

    // D/C is captured with the strobe and held through IDLE until the next byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_dc <= 1'b0;
        else if (w_accept) r_dc <= bus.tft_dc;
    end

endmodule

// File: tb/tb_tft_byte_sender.sv
// Directed bench for tft_byte_sender: two instances (CLK_DIV=2/CS_HOLD=1 and CLK_DIV=1/CS_HOLD=4).
// Latency: n/a.
// Backpressure: producer tasks wait for busy=0 before each strobe.
module tb_tft_byte_sender;

    localparam int A_DIV = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    tft_byte_sender_if a_if ();
    tft_byte_sender_if b_if ();

    tft_byte_sender #(.CLK_DIV(2), .CS_HOLD(1)) u_dut_a (.clk(clk), .rst(rst), .bus(a_if));
    tft_byte_sender #(.CLK_DIV(1), .CS_HOLD(4)) u_dut_b (.clk(clk), .rst(rst), .bus(b_if));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor for instance A (samples on falling clk) ----------------
    logic [8:0] rxq[$];
    int         blq[$];
    int         clq[$];
    int         cyc = 0;
    int         last_chg = -100;
    int         last_rise = -100;
    int         viol = 0;
    int         bitcnt = 0;
    int         blen = 0;
    int         clen = 0;
    logic [7:0] sh = 8'd0;
    logic       ps = 1'b0, pm = 1'b0, pd = 1'b0, pb = 1'b0, pc = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            bitcnt = 0;
            blen   = 0;
            clen   = 0;
        end else begin
            if (a_if.tft_cs) bitcnt = 0;
            if (a_if.tft_sck && !ps) begin
                if (cyc - last_chg < A_DIV) viol++;
                last_rise = cyc;
                sh = {sh[6:0], a_if.tft_mosi};
                bitcnt++;
                if (bitcnt == 8) begin
                    rxq.push_back({a_if.tft_dc_out, sh});
                    bitcnt = 0;
                end
            end
            if (!a_if.tft_cs && (a_if.tft_mosi != pm || a_if.tft_dc_out != pd)) begin
                if (cyc - last_rise < A_DIV) viol++;
                last_chg = cyc;
            end
            if (a_if.tft_busy) blen++;
            else if (pb) begin blq.push_back(blen); blen = 0; end
            if (!a_if.tft_cs) clen++;
            else if (!pc) begin clq.push_back(clen); clen = 0; end
        end
        ps = a_if.tft_sck;
        pm = a_if.tft_mosi;
        pd = a_if.tft_dc_out;
        pb = a_if.tft_busy;
        pc = a_if.tft_cs;
    end

    // ---------------- producer helpers ----------------
    task automatic send_a(input logic [7:0] d, input logic dc);
        a_if.tft_transmit = 1'b1;
        a_if.tft_data     = d;
        a_if.tft_dc       = dc;
        @(negedge clk);
        a_if.tft_transmit = 1'b0;
    endtask

    task automatic wait_idle_a(output int to);
        int n;
        n = 0;
        while (a_if.tft_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        to = (n >= 1000) ? 1 : 0;
    endtask

    task automatic flush_a();
        rxq.delete();
        blq.delete();
        clq.delete();
    endtask

    initial begin
        int         to;
        int         to_cnt;
        int         bad;
        int         nb, nr, nm;
        logic [7:0] rb;
        logic       psb;
        logic [8:0] e;

        a_if.tft_transmit = 1'b0; a_if.tft_data = 8'h00; a_if.tft_dc = 1'b0;
        b_if.tft_transmit = 1'b0; b_if.tft_data = 8'h00; b_if.tft_dc = 1'b0;

        // reset state on both instances
        repeat (3) @(negedge clk);
        chk("rst_a_busy", a_if.tft_busy, 0);
        chk("rst_a_cs", a_if.tft_cs, 1);
        chk("rst_a_sck", a_if.tft_sck, 0);
        chk("rst_a_mosi", a_if.tft_mosi, 0);
        chk("rst_a_dc_out", a_if.tft_dc_out, 0);
        chk("rst_b_busy", b_if.tft_busy, 0);
        chk("rst_b_cs", b_if.tft_cs, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // CLK_DIV=1, CS_HOLD=4: byte 0x80
        b_if.tft_transmit = 1'b1; b_if.tft_data = 8'h80; b_if.tft_dc = 1'b0;
        @(negedge clk);
        b_if.tft_transmit = 1'b0;
        chk("b_sck_first", b_if.tft_sck, 0);
        chk("b_mosi_first", b_if.tft_mosi, 1);
        nb = 0; nr = 0; nm = 0; rb = 8'd0; psb = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k == 1) chk("b_sck_rise_after_1", b_if.tft_sck, 1);
            if (b_if.tft_busy) nb++;
            if (b_if.tft_mosi) nm++;
            if (b_if.tft_sck && !psb) begin
                nr++;
                rb = {rb[6:0], b_if.tft_mosi};
            end
            psb = b_if.tft_sck;
            @(negedge clk);
        end
        chk("b_busy_len", nb, 20);
        chk("b_rises", nr, 8);
        chk("b_mosi_high_cycles", nm, 2);
        chk("b_byte", rb, 8'h80);
        chk("b_cs_idle", b_if.tft_cs, 1);

        // A: 0xA5 data byte
        flush_a();
        send_a(8'hA5, 1'b1);
        chk("a5_busy", a_if.tft_busy, 1);
        chk("a5_cs", a_if.tft_cs, 0);
        chk("a5_dc_out", a_if.tft_dc_out, 1);
        chk("a5_mosi_b7", a_if.tft_mosi, 1);
        chk("a5_sck", a_if.tft_sck, 0);
        wait_idle_a(to);
        chk("a5_timeout", to, 0);
        @(negedge clk);
        chk("a5_rx_cnt", rxq.size(), 1);
        e = (rxq.size() > 0) ? rxq.pop_front() : 9'h0;
        chk("a5_rx", e, 9'h1A5);
        chk("a5_busy_len", (blq.size() > 0) ? blq.pop_front() : -1, 33);
        chk("a5_cs_len", (clq.size() > 0) ? clq.pop_front() : -1, 33);
        chk("a5_idle_mosi", a_if.tft_mosi, 0);
        chk("a5_idle_dc_held", a_if.tft_dc_out, 1);

        // A: back-to-back 0x3A cmd then 0xD5 data at first busy=0 cycle
        flush_a();
        send_a(8'h3A, 1'b0);
        wait_idle_a(to);
        chk("b2b_timeout1", to, 0);
        send_a(8'hD5, 1'b1);
        chk("b2b_second_busy", a_if.tft_busy, 1);
        wait_idle_a(to);
        chk("b2b_timeout2", to, 0);
        @(negedge clk);
        chk("b2b_rx_cnt", rxq.size(), 2);
        e = (rxq.size() > 0) ? rxq.pop_front() : 9'h0;
        chk("b2b_rx0", e, 9'h03A);
        e = (rxq.size() > 0) ? rxq.pop_front() : 9'h0;
        chk("b2b_rx1", e, 9'h1D5);
        chk("b2b_frames", clq.size(), 2);

        // A: strobe 0x7B mid-byte of 0x00 is ignored
        flush_a();
        send_a(8'h00, 1'b1);
        repeat (10) @(negedge clk);
        send_a(8'h7B, 1'b0);
        chk("drop_dc_held", a_if.tft_dc_out, 1);
        wait_idle_a(to);
        chk("drop_timeout", to, 0);
        @(negedge clk);
        chk("drop_rx_cnt", rxq.size(), 1);
        e = (rxq.size() > 0) ? rxq.pop_front() : 9'h0;
        chk("drop_rx", e, 9'h100);
        chk("drop_busy_len", (blq.size() > 0) ? blq.pop_front() : -1, 33);

        // A: reset right after the 3rd SCK rise of 0xFF
        flush_a();
        send_a(8'hFF, 1'b1);
        repeat (10) @(negedge clk);
        chk("rst_mid_sck_pre", a_if.tft_sck, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", a_if.tft_busy, 0);
        chk("rst_mid_cs", a_if.tft_cs, 1);
        chk("rst_mid_sck", a_if.tft_sck, 0);
        chk("rst_mid_mosi", a_if.tft_mosi, 0);
        chk("rst_mid_dc_out", a_if.tft_dc_out, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_rx_none", rxq.size(), 0);
        flush_a();
        send_a(8'h0F, 1'b0);
        wait_idle_a(to);
        chk("rst_after_timeout", to, 0);
        @(negedge clk);
        e = (rxq.size() > 0) ? rxq.pop_front() : 9'h0;
        chk("rst_after_rx", e, 9'h00F);
        chk("rst_after_busy_len", (blq.size() > 0) ? blq.pop_front() : -1, 33);

        // A: scene of 960 strobes
        flush_a();
        to_cnt = 0;
        for (int i = 0; i < 960; i++) begin
            wait_idle_a(to);
            to_cnt += to;
            send_a(8'(i * 37 + 11), (i % 3) != 0);
        end
        wait_idle_a(to);
        to_cnt += to;
        @(negedge clk);
        chk("scene_timeouts", to_cnt, 0);
        chk("scene_rx_cnt", rxq.size(), 960);
        bad = 0;
        for (int i = 0; i < 960; i++) begin
            e = (rxq.size() > 0) ? rxq.pop_front() : 9'h0;
            if (e !== {((i % 3) != 0) ? 1'b1 : 1'b0, 8'(i * 37 + 11)}) bad++;
        end
        chk("scene_order_bad", bad, 0);
        bad = 0;
        foreach (blq[j]) if (blq[j] != 33) bad++;
        chk("scene_busy_len_bad", bad, 0);
        chk("scene_busy_frames", blq.size(), 960);
        chk("protocol_violations", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
